snake_game_ctrl: RTL and testbench
==================================

Name: snake_game_ctrl

Overview:
- Game sequencer that drives the snake body datapath.
- Turns frame pulses into tick requests and filters player direction input.
- Detects apple eating, places new apples off the snake body, and runs the game state machine (IDLE/RUN/DEAD/WON).
- Sits between the input/video timing logic and the snake datapath; apple position and score go to the renderer.

Parameters:
GAME_WIDTH, 30, playfield columns; legal x is 1..GAME_WIDTH (max 30).
GAME_HEIGHT, 14, playfield rows; legal y is 1..GAME_HEIGHT (max 14).
TICK_FRAMES, 8, initial frames per tick.
MIN_FRAMES, 2, floor for frames per tick.
SPEEDUP_APPLES, 4, apples eaten per 1-frame speed-up.
INIT_APPLE_X, 22, apple x after reset/restart.
INIT_APPLE_Y, 8, apple y after reset/restart.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_frame  in  1  one-cycle pulse per video frame
i_start  in  1  start button, level
i_btn  in  4  {up,down,left,right}, level
i_head_dir  in  2  current snake head direction
i_tick_done  in  1  snake accepted tick (one-cycle pulse)
i_pos_x/i_pos_y  in  5/4  snake scan position
i_pos_first/i_pos_last/i_pos_valid  in  1 each  snake scan qualifiers
i_head_x/i_head_y  in  5/4  snake head
i_failure/i_success  in  1 each  snake status
o_tick  out  1  tick request to snake
o_dir  out  2  direction for next tick (00 up, 01 down, 10 left, 11 right)
o_eat  out  1  one-cycle grow pulse to snake
o_snake_rst  out  1  active-high snake reset (inverted at top level)
o_apple_x/o_apple_y  out  5/4  apple position
o_apple_valid  out  1  apple placed and drawable
o_state  out  2  00 IDLE, 01 RUN, 10 DEAD, 11 WON
o_score  out  8  apples eaten, saturating at 255

Behaviour:
- Reset values: o_state=IDLE, o_tick=0, o_eat=0, o_dir=11, o_snake_rst=1, apple at (INIT_APPLE_X, INIT_APPLE_Y), o_apple_valid=1, o_score=0, frame counter=0, period=TICK_FRAMES, LFSR=16'hACE1, start edge register=0.
- Reset is asynchronous on every flop; asserting it mid-game aborts any pending tick, eat or relocation.
- Start: rising edge of i_start, registered edge detect.
- State transitions:
  - IDLE: o_snake_rst=1; start edge -> RUN.
  - RUN: o_snake_rst=0; i_failure -> DEAD; else i_success -> WON. Failure wins if both are asserted in the same cycle.
  - DEAD/WON: no ticks, no eats, outputs frozen; start edge -> IDLE, which restores the initial apple, score 0 and period TICK_FRAMES.
- Tick timing:
  - In RUN, each i_frame increments the frame counter.
  - When counter+1 reaches period, clear the counter and set o_tick.
  - o_tick holds until the cycle after i_tick_done; the frame counter is held while o_tick=1.
  - Leaving RUN clears o_tick.
- Direction:
  - The o_dir register updates any cycle o_tick=0 from i_btn, priority up > down > left > right.
  - A press whose code equals i_head_dir^2'b01 (a reversal) is ignored.
  - o_dir is stable while o_tick=1.
- Eating:
  - The eaten flag clears on i_tick_done.
  - In RUN, when i_pos_valid & i_pos_first, o_apple_valid=1, flag clear, and pos == apple: pulse o_eat for exactly one cycle, set the flag, o_score += 1 (saturating), and set o_apple_valid=0.
  - At most one eat per tick.
  - If i_failure is asserted in that cycle, o_eat and the score update are suppressed.
- Speed-up: every SPEEDUP_APPLES eats, period -= 1, floor MIN_FRAMES.
- Apple relocation sub-FSM (OK -> PICK -> WAIT -> CHECK):
  - PICK: the LFSR (x^16+x^14+x^13+x^11+1) advances every cycle. A sample is accepted when lfsr[4:0] < GAME_WIDTH and lfsr[11:8] < GAME_HEIGHT; the candidate is (lfsr[4:0]+1, lfsr[11:8]+1). Otherwise retry next cycle.
  - WAIT: wait for a scan start (i_pos_valid & i_pos_first).
  - CHECK: compare every valid scan position, including the start cycle, against the candidate. Any match -> PICK. Reaching i_pos_last with no match -> apple = candidate, o_apple_valid=1, OK.
  - Relocation continues in RUN only; it is abandoned when entering IDLE.

Test Plan:
- Reset then start edge, 8 i_frame pulses -> o_tick rises after the 8th frame, falls the cycle after i_tick_done; next tick after 8 more frames.
- Head moving right (i_head_dir=11), press left only -> o_dir stays 11; press up -> o_dir=00; button change while o_tick=1 -> o_dir unchanged.
- Scan with head (22,8) first, apple (22,8) -> o_eat high 1 cycle, o_score=1, o_apple_valid=0, then valid apple at a position not in the next scan.
- Force LFSR candidate onto a body segment -> CHECK rejects it, re-picks, and the final apple matches no scan position.
- i_failure and i_success both high in RUN -> o_state=10 (DEAD), no further o_tick; start edge -> IDLE with o_snake_rst=1, score 0; second start edge -> RUN.
- 4 eats with TICK_FRAMES=8 -> period 7; after 24 eats the period stays at 2; assert rst mid-tick -> o_tick=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: frame-to-tick pacing, direction filtering, apple eating and
// relocation, and the IDLE/RUN/DEAD/WON game state machine.
module snake_game_ctrl #(
  parameter int unsigned GAME_WIDTH     = 30,
  parameter int unsigned GAME_HEIGHT    = 14,
  parameter int unsigned TICK_FRAMES    = 8,
  parameter int unsigned MIN_FRAMES     = 2,
  parameter int unsigned SPEEDUP_APPLES = 4,
  parameter int unsigned INIT_APPLE_X   = 22,
  parameter int unsigned INIT_APPLE_Y   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame,
  input  logic       i_start,
  input  logic [3:0] i_btn,
  input  logic [1:0] i_head_dir,
  input  logic       i_tick_done,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic [4:0] i_head_x,
  input  logic [3:0] i_head_y,
  input  logic       i_failure,
  input  logic       i_success,
  output logic       o_tick,
  output logic [1:0] o_dir,
  output logic       o_eat,
  output logic       o_snake_rst,
  output logic [4:0] o_apple_x,
  output logic [3:0] o_apple_y,
  output logic       o_apple_valid,
  output logic [1:0] o_state,
  output logic [7:0] o_score
);
  typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StDead = 2'b10, StWon = 2'b11} state_e;
  typedef enum logic [1:0] {RelOk, RelPick, RelWait, RelCheck} rel_e;

  localparam logic [4:0] WidthLim    = 5'(GAME_WIDTH);
  localparam logic [3:0] HeightLim   = 4'(GAME_HEIGHT);
  localparam logic [7:0] TickInit    = 8'(TICK_FRAMES);
  localparam logic [7:0] MinFrames   = 8'(MIN_FRAMES);
  localparam logic [7:0] SpeedupLast = 8'(SPEEDUP_APPLES - 1);
  localparam logic [4:0] InitX       = 5'(INIT_APPLE_X);
  localparam logic [3:0] InitY       = 4'(INIT_APPLE_Y);

  state_e      state_q, state_d;
  rel_e        rel_q, rel_d;
  logic        start_q;
  logic        tick_q, tick_d;
  logic [1:0]  dir_q, dir_d;
  logic        eat_q, eat_d;
  logic        eaten_q, eaten_d;
  logic [4:0]  apple_x_q, apple_x_d;
  logic [3:0]  apple_y_q, apple_y_d;
  logic        apple_valid_q, apple_valid_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  period_q, period_d;
  logic [7:0]  spd_cnt_q, spd_cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  cand_x_q, cand_x_d;
  logic [3:0]  cand_y_q, cand_y_d;

  logic       start_edge, scan_start, cand_match, apple_hit;
  logic [1:0] btn_code;
  logic       unused_head;

  // Head position is consumed by the datapath, not by this sequencer.
  assign unused_head = ^{i_head_x, i_head_y};

  assign start_edge = i_start & ~start_q;
  assign scan_start = i_pos_valid & i_pos_first;
  assign cand_match = (i_pos_x == cand_x_q) && (i_pos_y == cand_y_q);
  assign apple_hit  = (state_q == StRun) && scan_start && apple_valid_q && !eaten_q &&
                      (i_pos_x == apple_x_q) && (i_pos_y == apple_y_q) && !i_failure;

  always_comb begin
    state_d       = state_q;
    rel_d         = rel_q;
    tick_d        = tick_q;
    dir_d         = dir_q;
    eat_d         = 1'b0;
    eaten_d       = eaten_q;
    apple_x_d     = apple_x_q;
    apple_y_d     = apple_y_q;
    apple_valid_d = apple_valid_q;
    score_d       = score_q;
    frame_cnt_d   = frame_cnt_q;
    period_d      = period_q;
    spd_cnt_d     = spd_cnt_q;
    lfsr_d        = lfsr_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    btn_code      = 2'b11;

    unique case (state_q)
      StIdle: if (start_edge) state_d = StRun;
      StRun: begin
        if (i_failure)      state_d = StDead;
        else if (i_success) state_d = StWon;
      end
      default: if (start_edge) state_d = StIdle;
    endcase

    // Only the highest-priority button counts; a reversal of it is simply dropped.
    if (i_btn[3])      btn_code = 2'b00;
    else if (i_btn[2]) btn_code = 2'b01;
    else if (i_btn[1]) btn_code = 2'b10;
    if (!tick_q && (state_q == StIdle || state_q == StRun) && (i_btn != 4'b0000) &&
        (btn_code != (i_head_dir ^ 2'b01))) begin
      dir_d = btn_code;
    end

    if (state_q == StRun) begin
      if (tick_q) begin
        if (i_tick_done) tick_d = 1'b0;
      end else if (i_frame) begin
        if (frame_cnt_q + 8'd1 >= period_q) begin
          frame_cnt_d = 8'd0;
          tick_d      = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
    end

    if (i_tick_done) eaten_d = 1'b0;

    if (apple_hit) begin
      eat_d         = 1'b1;
      eaten_d       = 1'b1;
      apple_valid_d = 1'b0;
      rel_d         = RelPick;
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
      if (spd_cnt_q == SpeedupLast) begin
        spd_cnt_d = 8'd0;
        if (period_q > MinFrames) period_d = period_q - 8'd1;
      end else begin
        spd_cnt_d = spd_cnt_q + 8'd1;
      end
    end

    if (state_q == StRun) begin
      unique case (rel_q)
        RelOk: ;
        RelPick: begin
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
          if (lfsr_q[4:0] < WidthLim && lfsr_q[11:8] < HeightLim) begin
            cand_x_d = lfsr_q[4:0] + 5'd1;
            cand_y_d = lfsr_q[11:8] + 4'd1;
            rel_d    = RelWait;
          end
        end
        RelWait: begin
          if (scan_start) begin
            if (cand_match) begin
              rel_d = RelPick;
            end else if (i_pos_last) begin
              apple_x_d     = cand_x_q;
              apple_y_d     = cand_y_q;
              apple_valid_d = 1'b1;
              rel_d         = RelOk;
            end else begin
              rel_d = RelCheck;
            end
          end
        end
        RelCheck: begin
          if (i_pos_valid) begin
            if (cand_match) begin
              rel_d = RelPick;
            end else if (i_pos_last) begin
              apple_x_d     = cand_x_q;
              apple_y_d     = cand_y_q;
              apple_valid_d = 1'b1;
              rel_d         = RelOk;
            end
          end
        end
      endcase
    end

    if (state_d != StRun) tick_d = 1'b0;

    // Going to (or sitting in) IDLE restores a fresh game and drops any relocation.
    if (state_d == StIdle) begin
      eat_d         = 1'b0;
      eaten_d       = 1'b0;
      frame_cnt_d   = 8'd0;
      period_d      = TickInit;
      spd_cnt_d     = 8'd0;
      score_d       = 8'd0;
      apple_x_d     = InitX;
      apple_y_d     = InitY;
      apple_valid_d = 1'b1;
      rel_d         = RelOk;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rel_q         <= RelOk;
      start_q       <= 1'b0;
      tick_q        <= 1'b0;
      dir_q         <= 2'b11;
      eat_q         <= 1'b0;
      eaten_q       <= 1'b0;
      apple_x_q     <= InitX;
      apple_y_q     <= InitY;
      apple_valid_q <= 1'b1;
      score_q       <= 8'd0;
      frame_cnt_q   <= 8'd0;
      period_q      <= TickInit;
      spd_cnt_q     <= 8'd0;
      lfsr_q        <= 16'hACE1;
      cand_x_q      <= 5'd0;
      cand_y_q      <= 4'd0;
    end else begin
      state_q       <= state_d;
      rel_q         <= rel_d;
      start_q       <= i_start;
      tick_q        <= tick_d;
      dir_q         <= dir_d;
      eat_q         <= eat_d;
      eaten_q       <= eaten_d;
      apple_x_q     <= apple_x_d;
      apple_y_q     <= apple_y_d;
      apple_valid_q <= apple_valid_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      period_q      <= period_d;
      spd_cnt_q     <= spd_cnt_d;
      lfsr_q        <= lfsr_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
    end
  end

  assign o_tick        = tick_q;
  assign o_dir         = dir_q;
  assign o_eat         = eat_q;
  assign o_snake_rst   = (state_q == StIdle);
  assign o_apple_x     = apple_x_q;
  assign o_apple_y     = apple_y_q;
  assign o_apple_valid = apple_valid_q;
  assign o_state       = state_q;
  assign o_score       = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Randomized bench for snake_game_ctrl against a game-rule model (tick period from eat count,
// apple candidates drawn from the LFSR stream, placement on the first body-free candidate).
module tb_snake_game_ctrl;
  localparam int GW = 30, GH = 14, TF = 8, MF = 2, SA = 4, IX = 22, IY = 8;

  logic       clk = 1'b0;
  logic       rst, frame, start, tick_done, pos_first, pos_last, pos_valid, failure, success;
  logic [3:0] btn;
  logic [1:0] head_dir;
  logic [4:0] pos_x, head_x;
  logic [3:0] pos_y, head_y;
  logic       o_tick, o_eat, o_snake_rst, o_apple_valid;
  logic [1:0] o_dir, o_state;
  logic [4:0] o_apple_x;
  logic [3:0] o_apple_y;
  logic [7:0] o_score;

  int checks = 0, failures = 0;
  int m_apple_x, m_apple_y, m_score, m_eats;
  logic [1:0]  m_dir;
  logic [15:0] m_lfsr;

  snake_game_ctrl dut (
    .clk(clk), .rst(rst), .i_frame(frame), .i_start(start), .i_btn(btn),
    .i_head_dir(head_dir), .i_tick_done(tick_done), .i_pos_x(pos_x), .i_pos_y(pos_y),
    .i_pos_first(pos_first), .i_pos_last(pos_last), .i_pos_valid(pos_valid),
    .i_head_x(head_x), .i_head_y(head_y), .i_failure(failure), .i_success(success),
    .o_tick(o_tick), .o_dir(o_dir), .o_eat(o_eat), .o_snake_rst(o_snake_rst),
    .o_apple_x(o_apple_x), .o_apple_y(o_apple_y), .o_apple_valid(o_apple_valid),
    .o_state(o_state), .o_score(o_score)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 5ms)", $time);
    $fatal(1);
  end

  function automatic int m_period();
    int p = TF - m_eats / SA;
    return (p < MF) ? MF : p;
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Next in-range candidate from the LFSR stream and how many PICK cycles it costs.
  task automatic next_cand(output int x, output int y, output int steps);
    steps = 0;
    while (!(int'(m_lfsr[4:0]) < GW && int'(m_lfsr[11:8]) < GH)) begin
      m_lfsr = lfsr_adv(m_lfsr);
      steps++;
    end
    x = int'(m_lfsr[4:0]) + 1;
    y = int'(m_lfsr[11:8]) + 1;
    m_lfsr = lfsr_adv(m_lfsr);
    steps++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic pulse_done();
    tick_done = 1'b1;
    step();
    tick_done = 1'b0;
  endtask

  task automatic scan_seg(input int x, input int y, input bit f, input bit l);
    pos_x = x[4:0];
    pos_y = y[3:0];
    pos_first = f;
    pos_last = l;
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    pos_first = 1'b0;
    pos_last = 1'b0;
  endtask

  task automatic frames_to_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
      if (o_tick) begin
        n = i;
        break;
      end
      step();
    end
  endtask

  // Scan starting on the apple; reports the cycle after the start and the one after that.
  task automatic eat_scan(output logic e, output logic [7:0] sc, output logic v,
                          output logic e_next);
    int x2 = (m_apple_x > 1) ? m_apple_x - 1 : m_apple_x + 1;
    scan_seg(m_apple_x, m_apple_y, 1'b1, 1'b0);
    e = o_eat;
    sc = o_score;
    v = o_apple_valid;
    scan_seg(x2, m_apple_y, 1'b0, 1'b0);
    e_next = o_eat;
    scan_seg(x2, (m_apple_y > 1) ? m_apple_y - 1 : m_apple_y + 1, 1'b0, 1'b1);
  endtask

  // Random-body scans until a candidate survives; force_hit lays the first candidate on the body.
  task automatic run_relocation(input bit force_hit, output bit placed, output logic v_first);
    int cx, cy, steps, n, k;
    int bx[5], by[5];
    bit hit;
    placed = 1'b0;
    v_first = 1'b1;
    for (int a = 0; a < 8 && !placed; a++) begin
      next_cand(cx, cy, steps);
      repeat (steps + 3) step();
      n = 3 + $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        bx[i] = 1 + $urandom_range(0, GW - 1);
        by[i] = 1 + $urandom_range(0, GH - 1);
      end
      if (force_hit && a == 0) begin
        k = $urandom_range(0, n - 1);
        bx[k] = cx;
        by[k] = cy;
      end
      hit = 1'b0;
      for (int i = 0; i < n; i++) if (bx[i] == cx && by[i] == cy) hit = 1'b1;
      for (int i = 0; i < n; i++) scan_seg(bx[i], by[i], i == 0, i == n - 1);
      if (a == 0) v_first = o_apple_valid;
      if (!hit) begin
        m_apple_x = cx;
        m_apple_y = cy;
        placed = 1'b1;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; frame = 0; start = 0; btn = 0; head_dir = 2'b11; tick_done = 0;
    pos_x = 0; pos_y = 0; pos_first = 0; pos_last = 0; pos_valid = 0;
    head_x = 5'd22; head_y = 4'd8; failure = 0; success = 0;
    m_apple_x = IX; m_apple_y = IY; m_score = 0; m_eats = 0; m_dir = 2'b11; m_lfsr = 16'hACE1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if ({o_state, o_tick, o_eat, o_dir, o_snake_rst} !== {2'b00, 1'b0, 1'b0, 2'b11, 1'b1}) begin
      failures++;
      $display("FAIL reset_ctrl: state=%b tick=%b eat=%b dir=%b snake_rst=%b, required 00 0 0 11 1",
               o_state, o_tick, o_eat, o_dir, o_snake_rst);
    end
    checks++;
    if ({o_apple_x, o_apple_y, o_apple_valid, o_score} !== {5'd22, 4'd8, 1'b1, 8'd0}) begin
      failures++;
      $display("FAIL reset_apple: apple=(%0d,%0d) valid=%b score=%0d, required (22,8) 1 0",
               o_apple_x, o_apple_y, o_apple_valid, o_score);
    end
  endtask

  task automatic test_tick();
    int n;
    press_start();
    checks++;
    if ({o_state, o_snake_rst} !== {2'b01, 1'b0}) begin
      failures++;
      $display("FAIL start_run: state=%b snake_rst=%b, required 01 0", o_state, o_snake_rst);
    end
    repeat (7) begin
      frame = 1'b1; step(); frame = 1'b0; step();
    end
    checks++;
    if (o_tick !== 1'b0) begin
      failures++;
      $display("FAIL tick_early: tick=%b after 7 frames, required 0", o_tick);
    end
    frame = 1'b1; step(); frame = 1'b0;
    checks++;
    if (o_tick !== 1'b1) begin
      failures++;
      $display("FAIL tick_rise: tick=%b after 8 frames, required 1", o_tick);
    end
    repeat (3) begin
      step(); frame = 1'b1; step(); frame = 1'b0;
    end
    checks++;
    if (o_tick !== 1'b1) begin
      failures++;
      $display("FAIL tick_hold: tick=%b before tick_done, required 1", o_tick);
    end
    pulse_done();
    checks++;
    if (o_tick !== 1'b0) begin
      failures++;
      $display("FAIL tick_fall: tick=%b after tick_done, required 0", o_tick);
    end
    frames_to_tick(n);
    checks++;
    if (n != m_period()) begin
      failures++;
      $display("FAIL tick_second: frames=%0d, required %0d", n, m_period());
    end
    pulse_done();
  endtask

  task automatic test_dir();
    int n;
    logic [1:0] code;
    head_dir = 2'b11;
    btn = 4'b0010;
    step();
    checks++;
    if (o_dir !== 2'b11) begin
      failures++;
      $display("FAIL dir_reverse: dir=%b, required 11", o_dir);
    end
    btn = 4'b1000;
    step();
    m_dir = 2'b00;
    checks++;
    if (o_dir !== 2'b00) begin
      failures++;
      $display("FAIL dir_up: dir=%b, required 00", o_dir);
    end
    for (int i = 0; i < 16; i++) begin
      btn = 4'($urandom_range(0, 15));
      head_dir = 2'($urandom_range(0, 3));
      step();
      if (btn != 4'b0000) begin
        code = btn[3] ? 2'd0 : btn[2] ? 2'd1 : btn[1] ? 2'd2 : 2'd3;
        if (code != (head_dir ^ 2'b01)) m_dir = code;
      end
      checks++;
      if (o_dir !== m_dir) begin
        failures++;
        $display("FAIL dir_random[%0d]: btn=%b head=%b dir=%b, required %b",
                 i, btn, head_dir, o_dir, m_dir);
      end
    end
    btn = 4'b0000;
    head_dir = 2'b11;
    frames_to_tick(n);
    checks++;
    if (n != m_period()) begin
      failures++;
      $display("FAIL dir_tick: frames=%0d, required %0d", n, m_period());
    end
    btn = (m_dir == 2'b11) ? 4'b1000 : 4'b0001;
    repeat (3) step();
    checks++;
    if (o_dir !== m_dir) begin
      failures++;
      $display("FAIL dir_stable: dir=%b while tick high, required %b", o_dir, m_dir);
    end
    pulse_done();
    step();
    m_dir = (m_dir == 2'b11) ? 2'b00 : 2'b11;
    checks++;
    if (o_dir !== m_dir) begin
      failures++;
      $display("FAIL dir_after_tick: dir=%b, required %b", o_dir, m_dir);
    end
    btn = 4'b0000;
  endtask

  task automatic test_eat(input bit force_hit, input string tag);
    logic e, v, e_next, v_first;
    logic [7:0] sc;
    bit placed;
    eat_scan(e, sc, v, e_next);
    m_eats++;
    if (m_score < 255) m_score++;
    checks++;
    if ({e, e_next, sc, v} !== {1'b1, 1'b0, m_score[7:0], 1'b0}) begin
      failures++;
      $display("FAIL %s_eat: eat=%b next=%b score=%0d valid=%b, required 1 0 %0d 0",
               tag, e, e_next, sc, v, m_score);
    end
    run_relocation(force_hit, placed, v_first);
    if (force_hit) begin
      checks++;
      if (v_first !== 1'b0) begin
        failures++;
        $display("FAIL %s_reject: valid=%b after colliding scan, required 0", tag, v_first);
      end
    end
    checks++;
    if ({o_apple_valid, o_apple_x, o_apple_y} !==
        {placed, m_apple_x[4:0], m_apple_y[3:0]}) begin
      failures++;
      $display("FAIL %s_place: valid=%b apple=(%0d,%0d), required %b (%0d,%0d)",
               tag, o_apple_valid, o_apple_x, o_apple_y, placed, m_apple_x, m_apple_y);
    end
  endtask

  task automatic test_speedup();
    int n;
    while (m_eats < 28) begin
      frames_to_tick(n);
      checks++;
      if (n != m_period()) begin
        failures++;
        $display("FAIL speed_period[eats=%0d]: frames=%0d, required %0d", m_eats, n, m_period());
      end
      pulse_done();
      test_eat(1'($urandom_range(0, 1)), "speed");
    end
    frames_to_tick(n);
    checks++;
    if (n != MF) begin
      failures++;
      $display("FAIL speed_floor: frames=%0d after %0d eats, required %0d", n, m_eats, MF);
    end
    pulse_done();
  endtask

  task automatic test_fail_restart();
    bit seen = 1'b0;
    failure = 1'b1;
    success = 1'b1;
    scan_seg(m_apple_x, m_apple_y, 1'b1, 1'b1);
    failure = 1'b0;
    success = 1'b0;
    checks++;
    if ({o_state, o_eat, o_score} !== {2'b10, 1'b0, m_score[7:0]}) begin
      failures++;
      $display("FAIL fail_dead: state=%b eat=%b score=%0d, required 10 0 %0d",
               o_state, o_eat, o_score, m_score);
    end
    repeat (12) begin
      frame = 1'b1; step(); frame = 1'b0; seen |= o_tick; step(); seen |= o_tick;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL dead_no_tick: tick seen=%b in DEAD, required 0", seen);
    end
    press_start();
    m_score = 0; m_eats = 0; m_apple_x = IX; m_apple_y = IY;
    checks++;
    if ({o_state, o_snake_rst, o_score, o_apple_valid, o_apple_x, o_apple_y} !==
        {2'b00, 1'b1, 8'd0, 1'b1, 5'd22, 4'd8}) begin
      failures++;
      $display("FAIL restart_idle: state=%b snake_rst=%b score=%0d valid=%b apple=(%0d,%0d), required 00 1 0 1 (22,8)",
               o_state, o_snake_rst, o_score, o_apple_valid, o_apple_x, o_apple_y);
    end
    press_start();
    checks++;
    if ({o_state, o_snake_rst} !== {2'b01, 1'b0}) begin
      failures++;
      $display("FAIL restart_run: state=%b snake_rst=%b, required 01 0", o_state, o_snake_rst);
    end
    success = 1'b1;
    step();
    success = 1'b0;
    checks++;
    if (o_state !== 2'b11) begin
      failures++;
      $display("FAIL won: state=%b, required 11", o_state);
    end
    press_start();
    press_start();
  endtask

  task automatic test_reset_mid_tick();
    int n;
    logic e, v, e_next;
    logic [7:0] sc;
    frames_to_tick(n);
    pulse_done();
    eat_scan(e, sc, v, e_next);
    checks++;
    if (e !== 1'b1) begin
      failures++;
      $display("FAIL mid_eat: eat=%b, required 1", e);
    end
    frames_to_tick(n);
    checks++;
    if (o_tick !== 1'b1) begin
      failures++;
      $display("FAIL mid_tick: tick=%b, required 1", o_tick);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({o_tick, o_state, o_snake_rst, o_eat, o_dir, o_score, o_apple_valid, o_apple_x, o_apple_y} !==
        {1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 8'd0, 1'b1, 5'd22, 4'd8}) begin
      failures++;
      $display("FAIL mid_reset: tick=%b state=%b snake_rst=%b eat=%b dir=%b score=%0d valid=%b apple=(%0d,%0d), required 0 00 1 0 11 0 1 (22,8)",
               o_tick, o_state, o_snake_rst, o_eat, o_dir, o_score, o_apple_valid, o_apple_x, o_apple_y);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_tick();
    test_dir();
    test_eat(1'b0, "eat");
    begin
      int n;
      frames_to_tick(n);
      checks++;
      if (n != m_period()) begin
        failures++;
        $display("FAIL collide_period: frames=%0d, required %0d", n, m_period());
      end
      pulse_done();
    end
    test_eat(1'b1, "collide");
    test_speedup();
    test_fail_restart();
    test_reset_mid_tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
